// File: rtl/mx_player_pkg.sv
// Purpose: shared types for the MX block vector player and the MX sum/dot benches.
//   state_e  : player FSM states
//   slot_t   : one stored vector at the default MXINT8 geometry
//   FLAG_*   : bit positions inside the result flag field
package mx_player_pkg;

    localparam int unsigned DEF_ELEM_W     = 8;
    localparam int unsigned DEF_BLOCK_SIZE = 32;
    localparam int unsigned DEF_SCALE_W    = 8;
    localparam int unsigned DEF_RES_W      = 32;
    localparam int unsigned DEF_FLAG_W     = 2;

    localparam int unsigned FLAG_UNUSED_BIT = 0;
    localparam int unsigned FLAG_OVF_BIT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_SCALE_W-1:0]                     scale;
        logic [DEF_BLOCK_SIZE-1:0][DEF_ELEM_W-1:0]  elements;
        logic [DEF_RES_W-1:0]                       expected;
        logic [DEF_FLAG_W-1:0]                      flags;
    } slot_t;

endpackage

// File: rtl/mx_player_checker.sv
// Purpose: in-order result checker for the MX block vector player.
//   i_clear / i_start   : zero everything / zero counters and result pointer
//   i_res_*             : DUT result beat (always accepted)
//   i_exp_*             : expectation of slot o_res_ptr, supplied by the top
//   i_n_vec             : number of filled slots (wrap point for o_res_ptr)
//   i_outst_nz          : at least one block is outstanding
//   o_pass/fail_cnt     : saturating match / mismatch counters
//   o_first_fail_*      : slot of the first mismatch, sticky
//   o_err_spurious      : result seen with nothing outstanding, sticky
module mx_player_checker
    import mx_player_pkg::*;
#(
    parameter int unsigned RES_W  = DEF_RES_W,
    parameter int unsigned FLAG_W = DEF_FLAG_W,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic              i_res_valid,
    input  logic [RES_W-1:0]  i_res_data,
    input  logic [FLAG_W-1:0] i_res_flags,
    input  logic [RES_W-1:0]  i_exp_data,
    input  logic [FLAG_W-1:0] i_exp_flags,
    input  logic [IDX_W:0]    i_n_vec,
    input  logic              i_outst_nz,
    output logic [IDX_W-1:0]  o_res_ptr,
    output logic [CNT_W-1:0]  o_pass_cnt,
    output logic [CNT_W-1:0]  o_fail_cnt,
    output logic              o_first_fail_vld,
    output logic [IDX_W-1:0]  o_first_fail_idx,
    output logic              o_err_spurious
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0] r_res_ptr;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_ff_vld;
    logic [IDX_W-1:0] r_ff_idx;
    logic             r_err_spur;

    logic             w_acc;
    logic             w_match;
    logic [IDX_W-1:0] w_ptr_nxt;

    assign w_acc     = i_res_valid && i_outst_nz;
    assign w_match   = {i_res_data, i_res_flags} == {i_exp_data, i_exp_flags};
    assign w_ptr_nxt = ({1'b0, r_res_ptr} == (i_n_vec - (IDX_W+1)'(1))) ? '0
                                                                         : r_res_ptr + IDX_W'(1);

    // Compare, count and latch the first failing slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_ptr  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
            r_err_spur <= 1'b0;
        end else if (i_clear) begin
            r_res_ptr  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
            r_err_spur <= 1'b0;
        end else begin
            if (i_start) begin
                r_res_ptr  <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else if (w_acc) begin
                r_res_ptr <= w_ptr_nxt;
                if (w_match) begin
                    if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end else begin
                    if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    if (!r_ff_vld) begin
                        r_ff_vld <= 1'b1;
                        r_ff_idx <= r_res_ptr;
                    end
                end
            end
            if (i_res_valid && !i_outst_nz) r_err_spur <= 1'b1;
        end
    end

    assign o_res_ptr        = r_res_ptr;
    assign o_pass_cnt       = r_pass_cnt;
    assign o_fail_cnt       = r_fail_cnt;
    assign o_first_fail_vld = r_ff_vld;
    assign o_first_fail_idx = r_ff_idx;
    assign o_err_spurious   = r_err_spur;

endmodule

// File: rtl/mx_block_vector_player.sv
// Purpose: stores up to DEPTH MX blocks with expectations, streams them to an
// MX datapath over valid/ready and checks returned results in order.
//   i_ld_*        : load port, accepted in IDLE while o_ld_ready
//   i_clear       : IDLE only, empties storage and zeroes counters/status
//   i_start       : begin playback; i_loop_mode sampled here; i_stop ends loop issue
//   o_out_*       : block presented to the datapath, i_out_ready accepts it
//   i_res_*       : result beats from the datapath, no backpressure
//   o_busy/o_done : playback in progress / one-cycle completion pulse
//   o_pass_cnt, o_fail_cnt, o_first_fail_*, o_err_spurious : checker status
module mx_block_vector_player
    import mx_player_pkg::*;
#(
    parameter int unsigned ELEM_W     = DEF_ELEM_W,
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned SCALE_W    = DEF_SCALE_W,
    parameter int unsigned RES_W      = DEF_RES_W,
    parameter int unsigned FLAG_W     = DEF_FLAG_W,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [SCALE_W-1:0]         i_ld_scale,
    input  logic [ELEM_W-1:0]          i_ld_elements [BLOCK_SIZE],
    input  logic [RES_W-1:0]           i_ld_expected,
    input  logic [FLAG_W-1:0]          i_ld_flags,
    input  logic                       i_clear,
    input  logic                       i_start,
    input  logic                       i_loop_mode,
    input  logic                       i_stop,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [SCALE_W-1:0]         o_out_scale,
    output logic [ELEM_W-1:0]          o_out_elements [BLOCK_SIZE],
    output logic [$clog2(DEPTH)-1:0]   o_out_idx,
    input  logic                       i_res_valid,
    input  logic [RES_W-1:0]           i_res_data,
    input  logic [FLAG_W-1:0]          i_res_flags,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [CNT_W-1:0]           o_pass_cnt,
    output logic [CNT_W-1:0]           o_fail_cnt,
    output logic                       o_first_fail_vld,
    output logic [$clog2(DEPTH)-1:0]   o_first_fail_idx,
    output logic                       o_err_spurious
);

    localparam int unsigned     IDX_W    = $clog2(DEPTH);
    localparam int unsigned     NV_W     = IDX_W + 1;
    localparam logic [NV_W-1:0] DEPTH_NV = NV_W'(DEPTH);

    state_e            r_state, w_state_nxt;
    logic [NV_W-1:0]   r_n_vec, w_n_vec_nxt;
    logic [NV_W-1:0]   r_outst, w_outst_nxt;
    logic [IDX_W-1:0]  r_issue_ptr, w_issue_nxt;
    logic              r_loop, w_loop_nxt;

    logic [SCALE_W-1:0] r_mem_scale [DEPTH];
    logic [ELEM_W-1:0]  r_mem_elem  [DEPTH][BLOCK_SIZE];
    logic [RES_W-1:0]   r_mem_exp   [DEPTH];
    logic [FLAG_W-1:0]  r_mem_flags [DEPTH];

    logic               r_ld_ready;
    logic               r_out_valid;
    logic [SCALE_W-1:0] r_out_scale;
    logic [ELEM_W-1:0]  r_out_elements [BLOCK_SIZE];
    logic [IDX_W-1:0]   r_out_idx;
    logic               r_busy;
    logic               r_done;

    logic               w_clear, w_start, w_load, w_xfer, w_res_acc, w_last;
    logic [IDX_W-1:0]   w_res_ptr;

    assign w_clear   = (r_state == ST_IDLE) && i_clear;
    assign w_start   = (r_state == ST_IDLE) && i_start && !i_clear;
    assign w_load    = (r_state == ST_IDLE) && i_ld_valid && r_ld_ready && !i_clear && !i_start;
    assign w_xfer    = (r_state == ST_PLAY) && r_out_valid && i_out_ready;
    assign w_res_acc = i_res_valid && (r_outst != '0);
    assign w_last    = {1'b0, r_issue_ptr} == (r_n_vec - NV_W'(1));

    // Next-state, pointers and outstanding count
    always_comb begin
        w_state_nxt = r_state;
        w_n_vec_nxt = r_n_vec;
        w_issue_nxt = r_issue_ptr;
        w_outst_nxt = r_outst;
        w_loop_nxt  = r_loop;

        // A transfer and a result in the same cycle cancel out
        if (w_xfer && !w_res_acc)      w_outst_nxt = r_outst + NV_W'(1);
        else if (!w_xfer && w_res_acc) w_outst_nxt = r_outst - NV_W'(1);

        if (w_xfer) w_issue_nxt = w_last ? '0 : r_issue_ptr + IDX_W'(1);

        unique case (r_state)
            ST_IDLE: begin
                if (w_clear) begin
                    w_n_vec_nxt = '0;
                end else if (w_start) begin
                    w_issue_nxt = '0;
                    w_outst_nxt = '0;
                    w_loop_nxt  = i_loop_mode;
                    w_state_nxt = (r_n_vec == '0) ? ST_DONE : ST_PLAY;
                end else if (w_load) begin
                    w_n_vec_nxt = r_n_vec + NV_W'(1);
                end
            end
            ST_PLAY: begin
                if (w_xfer && w_last && !r_loop) w_state_nxt = ST_DRAIN;
                else if (r_loop && i_stop)       w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_outst == '0) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; outputs are computed from next-state values so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_n_vec     <= '0;
            r_outst     <= '0;
            r_issue_ptr <= '0;
            r_loop      <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_scale <= '0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int j = 0; j < int'(BLOCK_SIZE); j++) r_out_elements[j] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_n_vec     <= w_n_vec_nxt;
            r_outst     <= w_outst_nxt;
            r_issue_ptr <= w_issue_nxt;
            r_loop      <= w_loop_nxt;
            r_ld_ready  <= (w_state_nxt == ST_IDLE) && (w_n_vec_nxt < DEPTH_NV);
            r_out_valid <= (w_state_nxt == ST_PLAY) && (w_outst_nxt != DEPTH_NV);
            r_busy      <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_DRAIN);
            r_done      <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
            if (w_state_nxt == ST_PLAY) begin
                r_out_scale <= r_mem_scale[w_issue_nxt];
                r_out_idx   <= w_issue_nxt;
                for (int j = 0; j < int'(BLOCK_SIZE); j++)
                    r_out_elements[j] <= r_mem_elem[w_issue_nxt][j];
            end else begin
                r_out_scale <= '0;
                r_out_idx   <= '0;
                for (int j = 0; j < int'(BLOCK_SIZE); j++) r_out_elements[j] <= '0;
            end
        end
    end

    // Vector storage, not reset
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_mem_scale[r_n_vec[IDX_W-1:0]] <= i_ld_scale;
            r_mem_exp[r_n_vec[IDX_W-1:0]]   <= i_ld_expected;
            r_mem_flags[r_n_vec[IDX_W-1:0]] <= i_ld_flags;
            for (int j = 0; j < int'(BLOCK_SIZE); j++)
                r_mem_elem[r_n_vec[IDX_W-1:0]][j] <= i_ld_elements[j];
        end
    end

    mx_player_checker #(
        .RES_W  (RES_W),
        .FLAG_W (FLAG_W),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) u_checker (
        .clk              (clk),
        .rst              (rst),
        .i_clear          (w_clear),
        .i_start          (w_start),
        .i_res_valid      (i_res_valid),
        .i_res_data       (i_res_data),
        .i_res_flags      (i_res_flags),
        .i_exp_data       (r_mem_exp[w_res_ptr]),
        .i_exp_flags      (r_mem_flags[w_res_ptr]),
        .i_n_vec          (r_n_vec),
        .i_outst_nz       (r_outst != '0),
        .o_res_ptr        (w_res_ptr),
        .o_pass_cnt       (o_pass_cnt),
        .o_fail_cnt       (o_fail_cnt),
        .o_first_fail_vld (o_first_fail_vld),
        .o_first_fail_idx (o_first_fail_idx),
        .o_err_spurious   (o_err_spurious)
    );

    assign o_ld_ready     = r_ld_ready;
    assign o_out_valid    = r_out_valid;
    assign o_out_scale    = r_out_scale;
    assign o_out_elements = r_out_elements;
    assign o_out_idx      = r_out_idx;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_mx_block_vector_player.sv
// Scoreboard bench for mx_block_vector_player: expected slot indices are queued
// before each run, a monitor checks every presented block against the queue and
// an echo model returns each block's stored expectation two cycles later.
module tb_mx_block_vector_player;
    import mx_player_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned BS    = 32;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [7:0]        ld_scale = '0;
    logic [7:0]        ld_elements [BS];
    logic [31:0]       ld_expected = '0;
    logic [1:0]        ld_flags = '0;
    logic              clear = 1'b0, start = 1'b0, loop_mode = 1'b0, stop = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_scale;
    logic [7:0]        out_elements [BS];
    logic [3:0]        out_idx;
    logic              res_valid = 1'b0;
    logic [31:0]       res_data = '0;
    logic [1:0]        res_flags = '0;
    logic              busy, done, ff_vld, err_spur;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt;
    logic [3:0]        ff_idx;

    mx_block_vector_player dut (
        .clk              (clk),
        .rst              (rst),
        .i_ld_valid       (ld_valid),
        .o_ld_ready       (ld_ready),
        .i_ld_scale       (ld_scale),
        .i_ld_elements    (ld_elements),
        .i_ld_expected    (ld_expected),
        .i_ld_flags       (ld_flags),
        .i_clear          (clear),
        .i_start          (start),
        .i_loop_mode      (loop_mode),
        .i_stop           (stop),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_scale      (out_scale),
        .o_out_elements   (out_elements),
        .o_out_idx        (out_idx),
        .i_res_valid      (res_valid),
        .i_res_data       (res_data),
        .i_res_flags      (res_flags),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass_cnt       (pass_cnt),
        .o_fail_cnt       (fail_cnt),
        .o_first_fail_vld (ff_vld),
        .o_first_fail_idx (ff_idx),
        .o_err_spurious   (err_spur)
    );

    slot_t tbl [DEPTH];
    int    exp_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    xfer_seen = 0;
    int    flip_idx = -1;
    int    mon_e;
    bit    echo_en = 1'b1;
    bit    inj_spur = 1'b0;

    bit          cap_v = 0, d0_v = 0, d1_v = 0;
    logic [31:0] cap_d = '0, d0_d = '0, d1_d = '0;
    logic [1:0]  cap_f = '0, d0_f = '0, d1_f = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented block must be the head of the expected queue
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL xfer_unexpected: got idx %0d expected no block", out_idx);
            end else begin
                mon_e = exp_q[0];
                check("out_fields",
                      64'({out_idx, out_scale, out_elements[0], out_elements[BS-1]}),
                      64'({4'(mon_e), tbl[mon_e].scale, tbl[mon_e].elements[0],
                           tbl[mon_e].elements[BS-1]}));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    xfer_seen++;
                    if (echo_en) begin
                        cap_v = 1'b1;
                        cap_d = tbl[mon_e].expected;
                        cap_f = tbl[mon_e].flags ^ ((mon_e == flip_idx) ? 2'b10 : 2'b00);
                    end
                end
            end
        end
    end

    // Echo datapath model: result two stages after the transfer
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            res_valid = 1'b0;
            d0_v = 0; d1_v = 0; cap_v = 0;
        end else begin
            res_valid = d1_v | inj_spur;
            res_data  = d1_d;
            res_flags = d1_f;
            d1_v = d0_v;  d1_d = d0_d;  d1_f = d0_f;
            d0_v = cap_v; d0_d = cap_d; d0_f = cap_f;
            cap_v = 1'b0;
        end
    end

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ld_valid    = 1'b1;
            ld_scale    = tbl[i].scale;
            ld_expected = tbl[i].expected;
            ld_flags    = tbl[i].flags;
            for (int j = 0; j < int'(BS); j++) ld_elements[j] = tbl[i].elements[j];
            for (int g = 0; g < 20; g++) begin
                @(negedge clk);
                if (ld_ready) break;
            end
        end
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
    endtask

    task automatic do_start(input bit lm);
        @(posedge clk); #1; start = 1'b1; loop_mode = lm;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic push_seq(input int n, input int wrap);
        for (int i = 0; i < n; i++) exp_q.push_back(i % wrap);
    endtask

    task automatic run(input bit toggle, output int dn);
        int tail;
        dn = 0;
        tail = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (dn > 0) tail++;
            if (tail > 3) break;
            @(posedge clk); #1;
            if (toggle) out_ready = !out_ready;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int dn;
        for (int i = 0; i < int'(DEPTH); i++) begin
            tbl[i].scale    = 8'(8'h20 + i);
            for (int j = 0; j < int'(BS); j++) tbl[i].elements[j] = 8'(i * 16 + j + 3);
            tbl[i].expected = 32'h3F80_0000 + 32'(i * 256 + 7);
            tbl[i].flags    = (i % 3 == 0) ? 2'b10 : 2'b00;
        end
        for (int j = 0; j < int'(BS); j++) ld_elements[j] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({ld_ready, out_valid, busy, done, ff_vld, err_spur,
                   pass_cnt, fail_cnt, ff_idx, out_idx, out_scale}), 64'(0));
        @(posedge clk); #1; rst = 1'b0;

        // Three vectors, single pass, always ready
        load(3);
        push_seq(3, 3);
        xfer_seen = 0;
        do_start(1'b0);
        run(1'b0, dn);
        check("A_done_pulses", 64'(dn), 64'(1));
        check("A_xfers", 64'(xfer_seen), 64'(3));
        check("A_pass", 64'(pass_cnt), 64'(3));
        check("A_fail", 64'(fail_cnt), 64'(0));
        check("A_idle", 64'({busy, ld_ready, ff_vld}), 64'(3'b010));

        // Rerun with slot 1 overflow flag corrupted
        flip_idx = 1;
        push_seq(3, 3);
        xfer_seen = 0;
        do_start(1'b0);
        run(1'b0, dn);
        flip_idx = -1;
        check("B_pass", 64'(pass_cnt), 64'(2));
        check("B_fail", 64'(fail_cnt), 64'(1));
        check("B_first_fail", 64'({ff_vld, ff_idx}), 64'({1'b1, 4'd1}));

        // Stalling consumer
        push_seq(3, 3);
        xfer_seen = 0;
        do_start(1'b0);
        run(1'b1, dn);
        check("C_done_pulses", 64'(dn), 64'(1));
        check("C_xfers", 64'(xfer_seen), 64'(3));
        check("C_pass", 64'(pass_cnt), 64'(3));

        // Loop mode, two vectors, stop coincides with the fifth transfer
        pulse_clear();
        load(2);
        push_seq(5, 2);
        xfer_seen = 0;
        do_start(1'b1);
        for (int k = 0; k < 100 && xfer_seen < 4; k++) begin
            @(posedge clk); #1;
        end
        stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        run(1'b0, dn);
        check("D_xfers", 64'(xfer_seen), 64'(5));
        check("D_queue_empty", 64'(exp_q.size()), 64'(0));
        check("D_pass", 64'(pass_cnt), 64'(5));
        check("D_fail", 64'(fail_cnt), 64'(0));
        check("D_done_pulses", 64'(dn), 64'(1));

        // Full storage; a 17th beat must be refused
        pulse_clear();
        load(int'(DEPTH));
        @(negedge clk);
        check("E_ld_ready_full", 64'(ld_ready), 64'(0));
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_scale = 8'hEE; ld_expected = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1; ld_valid = 1'b0;
        push_seq(int'(DEPTH), int'(DEPTH));
        xfer_seen = 0;
        do_start(1'b0);
        run(1'b0, dn);
        check("E_xfers", 64'(xfer_seen), 64'(16));
        check("E_pass", 64'(pass_cnt), 64'(16));
        check("E_fail", 64'(fail_cnt), 64'(0));
        check("E_ld_ready_after", 64'(ld_ready), 64'(0));

        // Empty start and spurious result
        pulse_clear();
        @(negedge clk);
        check("F_clear_status", 64'({pass_cnt, ff_vld, err_spur}), 64'(0));
        do_start(1'b0);
        @(negedge clk);
        check("F_empty_done", 64'(done), 64'(1));
        repeat (3) @(negedge clk);
        check("F_counters", 64'({pass_cnt, fail_cnt}), 64'(0));
        inj_spur = 1'b1;
        @(negedge clk); inj_spur = 1'b0;
        @(negedge clk);
        check("F_err_spurious", 64'(err_spur), 64'(1));
        check("F_pass_unchanged", 64'(pass_cnt), 64'(0));

        // Reset during playback with three blocks outstanding
        pulse_clear();
        load(4);
        echo_en = 1'b0;
        push_seq(4, 4);
        xfer_seen = 0;
        do_start(1'b0);
        for (int k = 0; k < 100 && xfer_seen < 3; k++) begin
            @(posedge clk); #1;
        end
        check("G_pre_rst_busy", 64'({busy, out_valid}), 64'(2'b11));
        rst = 1'b1;
        #1;
        check("G_rst_outputs",
              64'({ld_ready, out_valid, busy, done, ff_vld, err_spur,
                   pass_cnt, fail_cnt, out_idx, out_scale}), 64'(0));
        exp_q.delete();
        echo_en = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
        check("G_idle_ready", 64'({ld_ready, busy}), 64'(2'b10));
        do_start(1'b0);
        @(negedge clk);
        check("G_nvec_zero_done", 64'(done), 64'(1));
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mx_block_vector_player.md
# mx_block_vector_player

Synthesizable, parametrised successor to the file-driven MXINT8 sum stimulus driver. Holds up to DEPTH MX blocks (scale, elements, expected result, expected flags) loaded through a write port, streams them to a DUT with a valid/ready handshake, and checks returned results in order against the stored expectations. It sits between the FPGA/emulation host loader and any MX ALU datapath (sum, dot, convert). It replaces file I/O with on-chip vector storage and adds loop playback and pass/fail accounting.

## Interface
- ELEM_W, 8, element width (MXINT8 = 8)
- BLOCK_SIZE, 32, elements per MX block
- SCALE_W, 8, shared-scale width (E8M0)
- RES_W, 32, result width (float32)
- FLAG_W, 2, result flags; bit0 = unused, bit1 = overflow
- DEPTH, 16, vector slots (power of two, ≥2)
- CNT_W, 16, pass/fail counter width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  load beat valid
- ld_ready  out  1  high only in IDLE with fewer than DEPTH slots filled
- ld_scale  in  SCALE_W  scale to store
- ld_elements  in  ELEM_W×BLOCK_SIZE (unpacked [BLOCK_SIZE])  elements to store
- ld_expected  in  RES_W  expected result
- ld_flags  in  FLAG_W  expected flags
- clear  in  1  IDLE only: empties storage, zeroes counters/status
- start  in  1  begin playback (pulse)
- loop_mode  in  1  sampled at start; 1 = wrap to slot 0 after last slot
- stop  in  1  ends issue in loop mode (pulse)
- out_valid  out  1  block presented to DUT
- out_ready  in  1  DUT accepts block
- out_scale  out  SCALE_W  scale of current slot
- out_elements  out  ELEM_W×BLOCK_SIZE  elements of current slot
- out_idx  out  $clog2(DEPTH)  slot index of current block
- res_valid  in  1  DUT result valid (no backpressure, always accepted)
- res_data  in  RES_W  DUT result
- res_flags  in  FLAG_W  DUT flags
- busy  out  1  in PLAY or DRAIN
- done  out  1  one-cycle pulse on entering DONE
- pass_cnt  out  CNT_W  matching results, saturating
- fail_cnt  out  CNT_W  mismatching results, saturating
- first_fail_vld  out  1  sticky; a mismatch has occurred
- first_fail_idx  out  $clog2(DEPTH)  slot of first mismatch
- err_spurious  out  1  sticky; res_valid with zero outstanding

## Operation
- States: IDLE, PLAY, DRAIN, DONE. Reset → IDLE; all outputs 0, n_vec = 0.
- IDLE: ld_valid && ld_ready writes slot n_vec, n_vec += 1. clear has priority over load and start in the same cycle.
- start in IDLE: n_vec == 0 → DONE directly; otherwise issue_ptr = 0, res_ptr = 0, outstanding = 0 → PLAY. start outside IDLE is ignored.
- PLAY: out_valid = 1, out_* from slot issue_ptr. Transfer on out_valid && out_ready: issue_ptr += 1, outstanding += 1.
  - Last slot (n_vec−1) transferred with loop_mode = 0 → DRAIN.
  - loop_mode = 1: issue_ptr wraps to 0. stop (registered) → DRAIN; a transfer coinciding with stop still counts.
- Result: res_valid with outstanding > 0 compares {res_data, res_flags} against slot res_ptr, bit-exact. Match → pass_cnt++, else fail_cnt++; the first mismatch latches first_fail_idx. res_ptr advances and wraps at n_vec. Simultaneous transfer and result: outstanding unchanged.
- Outstanding is bounded to DEPTH. out_valid is held low while outstanding == DEPTH.
- DRAIN: out_valid = 0. outstanding == 0 → DONE.
- DONE: done pulses; next cycle → IDLE. Storage and counters are retained for re-run. start re-zeroes counters only.
- Counters saturate at 2^CNT_W−1.
- rst mid-operation: immediate return to IDLE, all outputs 0. Storage contents are undefined after rst.

## Timing
- start → out_valid high: next cycle.
- out_* stable while out_valid && !out_ready. The next slot is presented the cycle after a transfer, giving back-to-back throughput of 1 block/cycle.
- res_valid → pass_cnt/fail_cnt/first_fail_* update: next cycle.
- Final result → done pulse: 2 cycles (counter update, DRAIN→DONE).
- ld_ready falls the cycle after the DEPTH-th write.

## Structure
- Package mx_player_pkg holds the state enum, the slot struct typedef {scale, elements, expected, flags}, and the flag bit indices. These are shared with the MX sum/dot benches.
- One sub-module: mx_player_checker (result pointer, comparison, saturating counters, first-fail latch). The FSM, storage and issue path stay in the top.

## Test plan
- Load 3 vectors, loop_mode = 0, out_ready = 1, DUT echoes expected 2 cycles later → 3 transfers on idx 0,1,2; pass_cnt = 3, fail_cnt = 0; done pulses once; back in IDLE.
- Same load, but the result for slot 1 has its overflow flag flipped → fail_cnt = 1, first_fail_vld = 1, first_fail_idx = 1, pass_cnt = 2.
- out_ready toggles 1010… → out_* held constant while stalled; exactly n_vec transfers.
- loop_mode = 1 with 2 vectors; stop after 5 transfers → out_idx sequence 0,1,0,1,0; DRAIN waits for 5 results; pass_cnt = 5.
- Load DEPTH vectors → ld_ready low after the 16th write; a 17th ld_valid is not stored. start with n_vec = 0 → done the next cycle, counters 0. res_valid in IDLE → err_spurious = 1.
- rst asserted in PLAY with outstanding = 3 → all outputs 0 in the same cycle; after release, IDLE with n_vec = 0 and ld_ready = 1.
